uart_cmd_rx: RTL
================

Name: uart_cmd_rx

Overview:
- Serial receiver for the BLE command link into the Segway. It deserializes 8N1 UART frames from the RX pin, for example 'G' (0x47) for power-up and 'S' (0x53) for stop.
- Presents each received byte with a ready/clear handshake to the command-processing logic.
- Flags framing errors and overrun so that bad or lost commands are never silently accepted.
- Its far end is the existing UART_tx at the same baud setting.

Parameters:
- BAUD_CNT, 2604: clocks per bit (50 MHz / 19200 baud).
- HALF_CNT, 1302: clocks from the start-bit falling edge to the start-bit mid-point (BAUD_CNT/2).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- RX  in  1  serial input, idle high, asynchronous to clk
- clr_rdy  in  1  consumer acknowledge; clears rdy, frm_err and ovr
- rx_data  out  8  last received byte, LSB first on the wire
- rdy  out  1  byte valid; held until clr_rdy
- frm_err  out  1  sticky; stop bit sampled low
- ovr  out  1  sticky; a byte completed while rdy was already 1

Behaviour:
- Reset (async, rst=1) forces:
  - rx_data=8'h00, rdy=0, frm_err=0, ovr=0.
  - Synchronizer flops = 1 (idle).
  - state=IDLE, baud counter=0, bit counter=0.
- RX passes through a 2-flop synchronizer. Edge detection and sampling use only the synchronized signal. Add one extra flop for falling-edge detection.
- State machine:
  - IDLE: on a synchronized falling edge, load baud_cnt=HALF_CNT and go to START.
  - START: count down. At zero, sample:
    - sample = 1: glitch; return to IDLE, no flags touched.
    - sample = 0: load BAUD_CNT, bit_cnt=0, go to RECV.
  - RECV: count down; at each zero, sample RX into a shift register (right shift, new bit into MSB) and increment bit_cnt.
    - bit_cnt 0..7 are data bits. The 9th sample is the stop bit.
    - Stop=1: on the next clk, rx_data ← shift register, rdy ← 1; if rdy was already 1, ovr ← 1 and rx_data is overwritten with the new byte.
    - Stop=0: frm_err ← 1; rx_data and rdy unchanged.
    - Return to IDLE in both cases. Resynchronization needs RX to go high then fall again.
- Sample point: every bit is sampled at its mid-point ±1 clk.
- Latency: rdy rises (9.5 × BAUD_CNT) + 3 ±1 clks after the RX-pin falling edge of the start bit.
- clr_rdy:
  - Synchronous; clears rdy, frm_err and ovr on the next clk.
  - If clr_rdy and a byte completion occur in the same cycle, completion wins: rdy=1, rx_data=new byte, ovr not set.
- Back-to-back frames (stop bit followed immediately by the next start bit) must be received without loss. IDLE must be re-entered before the next falling edge, i.e. within half a bit.
- RX held low indefinitely (break condition): one frame is received with frm_err=1. No further frames are received until RX returns high.
- Reset mid-frame: all state is discarded immediately and no partial byte is reported. After release, the receiver waits for a fresh falling edge. A falling edge already in progress at release, or RX low at release, is not treated as a start.
- Counters:
  - baud counter is 12 bits.
  - bit counter is 4 bits and never exceeds 9.
  - No wrap-around is reachable in legal operation.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, RECV} rx_state_t
  - localparams BAUD_CNT_19200=2604 and HALF_CNT_19200=1302
  - localparams for command byte constants CMD_GO=8'h47 and CMD_STOP=8'h53
- One natural sub-module, rx_sync: a 2-flop synchronizer with a set-to-1 async reset and a registered falling-edge output.

Test Plan:
- Loopback single byte: UART_tx sends 8'h47.
  - Expect rdy=1 and rx_data=8'h47 at (9.5×2604)+3 ±1 clks after the TX start edge.
  - frm_err=0, ovr=0.
  - Pulse clr_rdy → rdy=0 the next clk.
- Back-to-back: send 8'h47, 8'h53, 8'hA5 with no idle gap, pulsing clr_rdy after each rdy.
  - Expect all three bytes in order with no flags set.
  - 8'hA5 checks LSB-first ordering.
- Overrun: send 8'h47 then 8'h53 without clr_rdy.
  - Expect rx_data=8'h53, rdy=1, ovr=1.
  - clr_rdy clears both rdy and ovr.
- Framing error: hand-drive RX as start bit, 8'h55, then stop=0 for one bit, then high.
  - Expect frm_err=1, rdy=0, rx_data unchanged.
  - A following good 8'h47 sets rdy with frm_err still 1 until clr_rdy.
- Glitch rejection: drive RX low for 500 clks (< HALF_CNT), then high.
  - Expect state back to IDLE, no rdy, no frm_err.
  - A subsequent 8'h47 is received correctly.
- Reset mid-frame: assert rst for 5 clks during bit 4 of 8'h47.
  - Expect all outputs zero immediately (async).
  - No rdy for the remainder of that frame.
  - The next full frame 8'h53 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the BLE command UART receiver.
// Baud figures assume a 50 MHz core clock at 19200 baud.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, RECV} rx_state_t;

  localparam int BAUD_CNT_19200 = 2604;
  localparam int HALF_CNT_19200 = 1302;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for RX plus an edge-history flop for falling-edge detection.
// Two-clock latency; no backpressure.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_vld;
  logic       r_armed;

  // A fall only counts once a genuine high has come through both sync stages
  // after reset, so a line that is low at release is not taken as a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_prev  <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_vld  <= {r_vld[0], 1'b1};
      if (r_vld[1] && r_sync) r_armed <= 1'b1;
    end
  end

  assign o_rx   = r_sync;
  assign o_fall = r_armed & r_prev & ~r_sync;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: byte out with rdy/clr_rdy handshake, sticky frm_err and ovr.
// rdy rises 9.5 bit times + 3 clks after the start edge; an unacknowledged byte is overwritten and flags ovr.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CNT = BAUD_CNT_19200,
  parameter int HALF_CNT = HALF_CNT_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam logic [11:0] LP_BAUD_RELOAD = 12'(BAUD_CNT - 1);
  localparam logic [11:0] LP_HALF_RELOAD = 12'(HALF_CNT - 1);

  logic       w_rx;
  logic       w_fall;

  rx_state_t   r_state;
  logic [11:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rdy;
  logic        r_frm_err;
  logic        r_ovr;

  rx_sync u_rx_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (RX),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

  // Frame completion is written after the clr_rdy clears, so it wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (clr_rdy) begin
        r_rdy     <= 1'b0;
        r_frm_err <= 1'b0;
        r_ovr     <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_baud_cnt <= LP_HALF_RELOAD;
            r_state    <= START;
          end
        end
        START: begin
          if (r_baud_cnt == 12'd0) begin
            if (w_rx) begin
              r_state <= IDLE;
            end else begin
              r_baud_cnt <= LP_BAUD_RELOAD;
              r_bit_cnt  <= 4'd0;
              r_state    <= RECV;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
          end
        end
        RECV: begin
          if (r_baud_cnt == 12'd0) begin
            r_baud_cnt <= LP_BAUD_RELOAD;
            if (r_bit_cnt == 4'd8) begin
              // Stop bit sampled at mid-bit; half a bit remains to catch the next start.
              if (w_rx) begin
                r_rx_data <= r_shift;
                r_rdy     <= 1'b1;
                if (r_rdy && !clr_rdy) r_ovr <= 1'b1;
              end else begin
                r_frm_err <= 1'b1;
              end
              r_bit_cnt <= 4'd0;
              r_state   <= IDLE;
            end else begin
              r_shift   <= {w_rx, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign ovr     = r_ovr;

endmodule
